dm_port_arbiter: RTL and testbench

- Shares the single-port word-addressed data memory between two requesters: port 0 (pipeline MEM stage) and port 1 (DMA/debug loader).
- Round-robin arbitration with one grant per cycle and registered read return.
- Includes a clear sequencer that zero-fills the whole memory on command.
- Sits between the requesters and the data memory; drives the memory's address, write-data and write-enable, and consumes its combinational read data.

---
 rtl/dm_port_arbiter_if.sv | 41 ++++
 rtl/dm_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter_if
// Request/response bundle for the two data-memory requesters.
//   port 0 : pipeline MEM stage     (req0/we0/addr0/wdata0 -> gnt0/rvalid0/rdata0/err0)
//   port 1 : DMA / debug loader     (req1/we1/addr1/wdata1 -> gnt1/rvalid1/rdata1/err1)
// modport master : requester side (drives requests, observes responses)
// modport slave  : arbiter side   (observes requests, drives responses)
// -----------------------------------------------------------------------------
interface dm_port_arbiter_if;
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        gnt0;
    logic        rvalid0;
    logic [31:0] rdata0;
    logic        err0;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        gnt1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic        err1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0, err0,
        input  gnt1, rvalid1, rdata1, err1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0, err0,
        output gnt1, rvalid1, rdata1, err1
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
// Shares one single-port, word-addressed data memory between two requesters
// with round-robin arbitration (one grant per cycle), a registered read
// return, and a clear sequencer that zero-fills the whole memory.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   bus        requester bundle (dm_port_arbiter_if.slave)
//   clr_start  pulse: start a full-memory zero fill
//   clr_busy   high during every clear write cycle
//   clr_done   one-cycle pulse after the last clear write
//   mem_addr   byte address to memory
//   mem_wdata  write data to memory
//   mem_we     memory write enable
//   mem_rdata  combinational read data from memory
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    dm_port_arbiter_if.slave     bus,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_we,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic          rr_last;     // index of the most recently granted port
    logic [AW-1:0] cnt;

    logic          arb_ok;
    logic          gnt0_c;
    logic          gnt1_c;
    logic          in_range0;
    logic          in_range1;
    logic [31:0]   word0;
    logic [31:0]   word1;

    logic          vld0_p1;
    logic          vld1_p1;
    logic          err0_p1;
    logic          err1_p1;
    logic [31:0]   rdata0_p1;
    logic [31:0]   rdata1_p1;
    logic          done_p1;

    function automatic logic word_in_range(input logic [31:0] word);
        return word < 32'(DEPTH);
    endfunction

    // The shift drops addr[1:0]: every access is word-aligned.
    assign word0     = bus.addr0 >> 2;
    assign word1     = bus.addr1 >> 2;
    assign in_range0 = word_in_range(word0);
    assign in_range1 = word_in_range(word1);

    // A clear command in IDLE wins over both requesters for that cycle; grants
    // are also held off while reset is asserted so nothing reaches the memory.
    always_comb begin
        arb_ok = reset && (state == IDLE) && !clr_start;
        gnt0_c = arb_ok && bus.req0 && (!bus.req1 || rr_last);
        gnt1_c = arb_ok && bus.req1 && (!bus.req0 || !rr_last);
    end

    assign bus.gnt0 = gnt0_c;
    assign bus.gnt1 = gnt1_c;

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 1'b0;
        if (reset && (state == CLEAR)) begin
            mem_addr  = 32'({cnt, 2'b00});
            mem_wdata = 32'd0;
            mem_we    = 1'b1;
        end else if (gnt0_c) begin
            mem_addr  = word0 << 2;
            mem_wdata = bus.wdata0;
            mem_we    = bus.we0 && in_range0;
        end else if (gnt1_c) begin
            mem_addr  = word1 << 2;
            mem_wdata = bus.wdata1;
            mem_we    = bus.we1 && in_range1;
        end
    end

    // ---- grant cycle (p0) -> return cycle (p1) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            cnt       <= '0;
            vld0_p1   <= 1'b0;
            vld1_p1   <= 1'b0;
            err0_p1   <= 1'b0;
            err1_p1   <= 1'b0;
            rdata0_p1 <= 32'd0;
            rdata1_p1 <= 32'd0;
            done_p1   <= 1'b0;
        end else begin
            vld0_p1 <= gnt0_c && !bus.we0;
            vld1_p1 <= gnt1_c && !bus.we1;
            err0_p1 <= gnt0_c && !in_range0;
            err1_p1 <= gnt1_c && !in_range1;
            // rdataN only moves on a read of that port; out-of-range reads return 0.
            if (gnt0_c && !bus.we0)
                rdata0_p1 <= in_range0 ? mem_rdata : 32'd0;
            if (gnt1_c && !bus.we1)
                rdata1_p1 <= in_range1 ? mem_rdata : 32'd0;
            done_p1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (gnt0_c) begin
                        rr_last <= 1'b0;
                    end else if (gnt1_c) begin
                        rr_last <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    // Leave on the last index so the counter never wraps.
                    if (cnt == AW'(DEPTH - 1)) begin
                        state   <= IDLE;
                        done_p1 <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rvalid0 = vld0_p1;
    assign bus.rvalid1 = vld1_p1;
    assign bus.rdata0  = rdata0_p1;
    assign bus.rdata1  = rdata1_p1;
    assign bus.err0    = err0_p1;
    assign bus.err1    = err1_p1;
    assign clr_busy    = (state == CLEAR);
    assign clr_done    = done_p1;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
// Directed bench for dm_port_arbiter with a behavioural memory model.
// Read expectations are queued when a grant is observed; a monitor pops and
// compares them whenever rvalid0/rvalid1 is presented.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    dm_port_arbiter_if bus_if ();

    dm_port_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word i initialised to 0xA500_0000 | i.
    logic [31:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[11:2]];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push0(input logic [31:0] d, input logic e);
        exp_t x;
        x.d = d; x.e = e;
        q0.push_back(x);
    endtask

    task automatic push1(input logic [31:0] d, input logic e);
        exp_t x;
        x.d = d; x.e = e;
        q1.push_back(x);
    endtask

    // Monitor: compares every presented read return against the queue.
    always @(negedge clk) begin : mon
        exp_t x;
        if (bus_if.rvalid0) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd0_unexpected: rvalid0 with no pending read, rdata0=%h", bus_if.rdata0);
            end else begin
                x = q0.pop_front();
                chk("rd0_data", bus_if.rdata0, x.d);
                chk("rd0_err", 32'(bus_if.err0), 32'(x.e));
            end
        end else if (bus_if.err0) begin
            n_cmp++; n_bad++;
            $display("FAIL err0_unexpected: err0=1 expected 0 (t=%0t)", $time);
        end
        if (bus_if.rvalid1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd1_unexpected: rvalid1 with no pending read, rdata1=%h", bus_if.rdata1);
            end else begin
                x = q1.pop_front();
                chk("rd1_data", bus_if.rdata1, x.d);
                chk("rd1_err", 32'(bus_if.err1), 32'(x.e));
            end
        end else if (bus_if.err1) begin
            n_cmp++; n_bad++;
            $display("FAIL err1_unexpected: err1=1 expected 0 (t=%0t)", $time);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int bad;
        int dn;
        int quiet;

        reset        = 1'b0;
        clr_start    = 1'b0;
        bus_if.req0  = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 32'h4; bus_if.wdata0 = 32'd0;
        bus_if.req1  = 1'b1; bus_if.we1 = 1'b0; bus_if.addr1 = 32'h8; bus_if.wdata1 = 32'd0;

        // Reset state, both requests held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid0", 32'(bus_if.rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(bus_if.rvalid1), 32'd0);
        chk("rst_rdata0", bus_if.rdata0, 32'd0);
        chk("rst_rdata1", bus_if.rdata1, 32'd0);
        chk("rst_err0", 32'(bus_if.err0), 32'd0);
        chk("rst_err1", 32'(bus_if.err1), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Contention: gnt0, gnt1, gnt0, gnt1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("rr_gnt0", 32'(bus_if.gnt0), 32'd1);
                chk("rr_gnt1", 32'(bus_if.gnt1), 32'd0);
                chk("rr_addr", mem_addr, 32'h4);
                push0(32'hA500_0001, 1'b0);
            end else begin
                chk("rr_gnt0", 32'(bus_if.gnt0), 32'd0);
                chk("rr_gnt1", 32'(bus_if.gnt1), 32'd1);
                chk("rr_addr", mem_addr, 32'h8);
                push1(32'hA500_0002, 1'b0);
            end
            @(posedge clk); #1;
        end
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;

        // Single requester, back-to-back reads of words 0..4
        bus_if.req0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_if.addr0 = 32'(4 * i);
            @(negedge clk);
            chk("b2b_gnt0", 32'(bus_if.gnt0), 32'd1);
            chk("b2b_addr", mem_addr, 32'(4 * i));
            if (i > 0) chk("b2b_rvalid0", 32'(bus_if.rvalid0), 32'd1);
            push0(32'hA500_0000 | 32'(i), 1'b0);
            @(posedge clk); #1;
        end
        bus_if.req0 = 1'b0;
        @(negedge clk);
        chk("b2b_rvalid0_last", 32'(bus_if.rvalid0), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_rvalid0_end", 32'(bus_if.rvalid0), 32'd0);
        @(posedge clk); #1;

        // Port 0 write, then port 1 read of the same word
        bus_if.req0 = 1'b1; bus_if.we0 = 1'b1; bus_if.addr0 = 32'h10; bus_if.wdata0 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_gnt0", 32'(bus_if.gnt0), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        bus_if.req0 = 1'b0; bus_if.we0 = 1'b0;
        bus_if.req1 = 1'b1; bus_if.we1 = 1'b0; bus_if.addr1 = 32'h10;
        @(negedge clk);
        chk("rd1_gnt1", 32'(bus_if.gnt1), 32'd1);
        chk("rd1_mem_we", 32'(mem_we), 32'd0);
        chk("wr_no_rvalid0", 32'(bus_if.rvalid0), 32'd0);
        push1(32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;

        // Out-of-range read on port 1 (word 1024)
        bus_if.addr1 = 32'h1000;
        @(negedge clk);
        chk("oor_gnt1", 32'(bus_if.gnt1), 32'd1);
        chk("oor_mem_we", 32'(mem_we), 32'd0);
        push1(32'd0, 1'b1);
        @(posedge clk); #1;
        bus_if.req1 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        // Clear together with a port 0 read of 0x10
        bus_if.req0 = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 32'h10;
        clr_start = 1'b1;
        @(negedge clk);
        chk("clr_blocks_gnt0", 32'(bus_if.gnt0), 32'd0);
        chk("rdata0_hold", bus_if.rdata0, 32'hA500_0004);
        @(posedge clk); #1;
        clr_start = 1'b0;
        n = 0; bad = 0; dn = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (!clr_busy) break;
            if (mem_we !== 1'b1 || mem_wdata !== 32'd0 || mem_addr !== 32'(n * 4) || bus_if.gnt0 !== 1'b0)
                bad++;
            if (clr_done) dn++;
            n++;
        end
        chk("clr_busy_cycles", 32'(n), 32'd1024);
        chk("clr_sweep_bad", 32'(bad), 32'd0);
        chk("clr_done_early", 32'(dn), 32'd0);
        chk("clr_done_pulse", 32'(clr_done), 32'd1);
        chk("clr_then_gnt0", 32'(bus_if.gnt0), 32'd1);
        push0(32'd0, 1'b0);
        @(posedge clk); #1;
        bus_if.req0 = 1'b0;
        @(negedge clk);
        chk("clr_done_once", 32'(clr_done), 32'd0);
        @(posedge clk); #1;

        // Reset at clear counter 500
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (clr_busy && mem_addr == 32'h7D0) break;
        end
        chk("mid_reached", mem_addr, 32'h7D0);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(clr_busy), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_done", 32'(clr_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (clr_busy || clr_done) quiet++;
        end
        chk("mid_rst_quiet", 32'(quiet), 32'd0);
        @(posedge clk); #1;
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        @(negedge clk);
        chk("reclr_busy", 32'(clr_busy), 32'd1);
        chk("reclr_addr0", mem_addr, 32'd0);
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (!clr_busy) break;
        end
        chk("reclr_done", 32'(clr_done), 32'd1);

        // Every queued read must have been returned
        repeat (2) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
